// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin RAM bus arbiter.
//   arb_state_t     : arbiter FSM states
//   ARB_TMO_DEFAULT : hold limit loaded at reset
//   clog2_min1      : ceil(log2(n)), never less than 1, for index widths
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_TMO_DEFAULT = 64;

  // A single requester would otherwise give a zero-width index
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection.
//   req    : request vector, one bit per requester
//   ptr    : index of the most recent winner; the search starts just after it
//   winner : index of the first set request at or after ptr+1 (wrapping)
//   valid  : at least one request is set
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] start;
  logic [N-1:0]     rotated;
  logic [IDX_W-1:0] offset;
  logic [IDX_W:0]   sum;

  // Rotate so that bit 0 is the first candidate, take the lowest set bit,
  // then add the rotation back modulo N to recover the absolute index.
  always_comb begin
    start   = (ptr == IDX_W'(N - 1)) ? '0 : ptr + IDX_W'(1);
    rotated = N'({req, req} >> start);
    offset  = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rotated[j]) offset = IDX_W'(j);
    end
    sum = {1'b0, offset} + {1'b0, start};
    if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
    winner = sum[IDX_W-1:0];
    valid  = |req;
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-way round-robin arbiter for one shared RAM port with a programmable
// hold limit. A holder is preempted after its limit only if someone else
// is waiting, and every handover passes through one idle cycle.
//   clock, reset (async, active-low)
//   en_timeout, timeout_value     : load a new hold limit (0 = never preempt)
//   req, r_wb_proc, addbus_proc,
//   datawritebus_proc             : per-requester level request and bus fields
//   ack, grant_id, bus_valid      : registered grant
//   r_wb_ram, addbus_ram,
//   datawritebus_ram              : holder's bus fields, idle values when no grant
//   timeout_pulse                 : one-cycle pulse on preemption
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int ADDR_W      = 12,
  parameter  int DATA_W      = 8,
  parameter  int TMO_W       = 8,
  parameter  int TMO_DEFAULT = ARB_TMO_DEFAULT,
  localparam int ID_W        = clog2_min1(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en_timeout,
  input  logic [TMO_W-1:0]          timeout_value,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        r_wb_proc,
  input  logic [NUM_REQ*ADDR_W-1:0] addbus_proc,
  input  logic [NUM_REQ*DATA_W-1:0] datawritebus_proc,
  output logic [NUM_REQ-1:0]        ack,
  output logic [ID_W-1:0]           grant_id,
  output logic                      bus_valid,
  output logic                      r_wb_ram,
  output logic [ADDR_W-1:0]         addbus_ram,
  output logic [DATA_W-1:0]         datawritebus_ram,
  output logic                      timeout_pulse
);

  arb_state_t       state;
  logic [TMO_W-1:0] lim;
  logic [TMO_W-1:0] lim_snap;
  logic [TMO_W-1:0] timer;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic             pick_valid;
  logic             others_waiting;
  logic             timer_at_end;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (pick_valid)
  );

  // With lim_snap = 0 the compare value is all ones, so the timer simply
  // saturates there and the expiry branch is masked by the non-zero check.
  always_comb begin
    others_waiting = |(req & ~ack);
    timer_at_end   = (timer == lim_snap - TMO_W'(1));
  end

  // The limit register can be reloaded in any state; the running grant
  // keeps its own snapshot so a reload only affects the next grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lim <= TMO_W'(TMO_DEFAULT);
    end else if (en_timeout) begin
      lim <= timeout_value;
    end
  end

  // Arbitration FSM with registered grant outputs. Leaving GRANT always
  // goes to IDLE so the bus sees one cycle with no owner between holders.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ack           <= '0;
      grant_id      <= '0;
      bus_valid     <= 1'b0;
      timeout_pulse <= 1'b0;
      timer         <= '0;
      lim_snap      <= TMO_W'(TMO_DEFAULT);
      ptr           <= ID_W'(NUM_REQ - 1);
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state     <= GRANT;
            ack       <= NUM_REQ'(1) << winner;
            grant_id  <= winner;
            bus_valid <= 1'b1;
            ptr       <= winner;
            timer     <= '0;
            lim_snap  <= lim;
          end
        end
        GRANT: begin
          if (!req[grant_id]) begin
            state     <= IDLE;
            ack       <= '0;
            grant_id  <= '0;
            bus_valid <= 1'b0;
          end else if (timer_at_end && (lim_snap != '0) && others_waiting) begin
            state         <= IDLE;
            ack           <= '0;
            grant_id      <= '0;
            bus_valid     <= 1'b0;
            timeout_pulse <= 1'b1;
          end else if (!timer_at_end) begin
            timer <= timer + TMO_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          ack       <= '0;
          grant_id  <= '0;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

  // Unpack the per-requester fields so the mux can index them by grant_id.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = addbus_proc[i*ADDR_W +: ADDR_W];
      data_arr[i] = datawritebus_proc[i*DATA_W +: DATA_W];
    end
  end

  // Output mux follows the registered grant, so it switches with ack.
  always_comb begin
    if (bus_valid) begin
      r_wb_ram         = r_wb_proc[grant_id];
      addbus_ram       = addr_arr[grant_id];
      datawritebus_ram = data_arr[grant_id];
    end else begin
      r_wb_ram         = 1'b1;
      addbus_ram       = '0;
      datawritebus_ram = '0;
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed testbench for rr_bus_arbiter (4 requesters, 12-bit address,
// 8-bit data, 8-bit timer). Expected grants are queued as each step is
// driven and popped once the clock edge has produced the DUT response.
module tb_rr_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        en_timeout;
  logic [7:0]  timeout_value;
  logic [3:0]  req;
  logic [3:0]  r_wb_proc;
  logic [47:0] addbus_proc;
  logic [31:0] datawritebus_proc;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        bus_valid;
  logic        r_wb_ram;
  logic [11:0] addbus_ram;
  logic [7:0]  datawritebus_ram;
  logic        timeout_pulse;

  typedef struct {
    logic [3:0] ack;
    logic [1:0] gid;
    logic       pulse;
  } exp_t;

  exp_t  expQ[$];
  int    assertCount = 0;
  int    failCount   = 0;
  string phase       = "reset";

  rr_bus_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .en_timeout        (en_timeout),
    .timeout_value     (timeout_value),
    .req               (req),
    .r_wb_proc         (r_wb_proc),
    .addbus_proc       (addbus_proc),
    .datawritebus_proc (datawritebus_proc),
    .ack               (ack),
    .grant_id          (grant_id),
    .bus_valid         (bus_valid),
    .r_wb_ram          (r_wb_ram),
    .addbus_ram        (addbus_ram),
    .datawritebus_ram  (datawritebus_ram),
    .timeout_pulse     (timeout_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [11:0] addrOf(input int i);
    return 12'h3A0 + 12'(i) * 12'h111;
  endfunction

  function automatic logic [7:0] dataOf(input int i);
    return 8'h5C + 8'(i) * 8'h21;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s.%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic en, input logic [7:0] val);
    req           = r;
    en_timeout    = en;
    timeout_value = val;
  endtask

  // Expected bus fields follow from the expected grant and the bench's
  // own address/data/direction constants.
  task automatic compareAll(input exp_t e);
    logic bv;
    bv = |e.ack;
    checkOutput("ack",   32'(ack),           32'(e.ack));
    checkOutput("gid",   32'(grant_id),      32'(e.gid));
    checkOutput("valid", 32'(bus_valid),     32'(bv));
    checkOutput("pulse", 32'(timeout_pulse), 32'(e.pulse));
    checkOutput("addr",  32'(addbus_ram),       bv ? 32'(addrOf(int'(e.gid))) : 32'd0);
    checkOutput("data",  32'(datawritebus_ram), bv ? 32'(dataOf(int'(e.gid))) : 32'd0);
    checkOutput("rwb",   32'(r_wb_ram),         bv ? 32'(r_wb_proc[e.gid]) : 32'd1);
  endtask

  task automatic checkCycle(input logic [3:0] a, input logic [1:0] g, input logic p);
    exp_t e;
    exp_t got;
    e.ack   = a;
    e.gid   = g;
    e.pulse = p;
    expQ.push_back(e);
    @(posedge clock);
    #1;
    got = expQ.pop_front();
    compareAll(got);
  endtask

  task automatic checkNow(input logic [3:0] a, input logic [1:0] g, input logic p);
    exp_t e;
    exp_t got;
    e.ack   = a;
    e.gid   = g;
    e.pulse = p;
    expQ.push_back(e);
    got = expQ.pop_front();
    compareAll(got);
  endtask

  // Invariants sampled every cycle on the falling edge.
  always @(negedge clock) begin
    checkOutput("inv.onehot0", 32'($onehot0(ack)), 32'd1);
    checkOutput("inv.valid",   32'(bus_valid),     32'(|ack));
    if (!bus_valid) begin
      checkOutput("inv.idle_addr", 32'(addbus_ram),       32'd0);
      checkOutput("inv.idle_data", 32'(datawritebus_ram), 32'd0);
      checkOutput("inv.idle_rwb",  32'(r_wb_ram),         32'd1);
    end
  end

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    reset     = 1'b0;
    r_wb_proc = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      addbus_proc[i*12 +: 12]     = addrOf(i);
      datawritebus_proc[i*8 +: 8] = dataOf(i);
    end
    applyStimulus(4'b0000, 1'b0, 8'd0);
    #2;
    checkNow(4'b0000, 2'd0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    $display("[TB] single requester grant latency");
    phase = "t1";
    applyStimulus(4'b0001, 1'b0, 8'd0);
    checkCycle(4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 8'd0);
    checkCycle(4'b0000, 2'd0, 1'b0);
    checkCycle(4'b0000, 2'd0, 1'b0);

    $display("[TB] all requesting, limit 4, rotation 0-1-2-3-0");
    phase = "t2";
    reset = 1'b0;
    #1;
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b1, 8'd4);
    checkCycle(4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        checkCycle(4'b0001 << order[k], 2'(order[k]), 1'b0);
      end
      checkCycle(4'b0000, 2'd0, 1'b1);
    end
    applyStimulus(4'b0000, 1'b0, 8'd0);
    checkCycle(4'b0000, 2'd0, 1'b0);

    $display("[TB] lone requester never preempted");
    phase = "t3";
    applyStimulus(4'b0000, 1'b1, 8'd64);
    checkCycle(4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 8'd0);
    for (int c = 0; c < 300; c++) begin
      checkCycle(4'b0100, 2'd2, 1'b0);
    end
    applyStimulus(4'b0000, 1'b0, 8'd0);
    checkCycle(4'b0000, 2'd0, 1'b0);

    $display("[TB] limit reload mid-grant applies to next grant");
    phase = "t4";
    applyStimulus(4'b0000, 1'b1, 8'd10);
    checkCycle(4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 8'd0);
    checkCycle(4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b0011, 1'b1, 8'd3);
    checkCycle(4'b0001, 2'd0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 8'd0);
    for (int c = 0; c < 8; c++) begin
      checkCycle(4'b0001, 2'd0, 1'b0);
    end
    checkCycle(4'b0000, 2'd0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checkCycle(4'b0010, 2'd1, 1'b0);
    end
    checkCycle(4'b0000, 2'd0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 8'd0);
    checkCycle(4'b0000, 2'd0, 1'b0);

    $display("[TB] zero limit holds until release");
    phase = "t5";
    applyStimulus(4'b0000, 1'b1, 8'd0);
    checkCycle(4'b0000, 2'd0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 8'd0);
    for (int c = 0; c < 300; c++) begin
      checkCycle(4'b0001, 2'd0, 1'b0);
    end
    applyStimulus(4'b0010, 1'b0, 8'd0);
    checkCycle(4'b0000, 2'd0, 1'b0);
    checkCycle(4'b0010, 2'd1, 1'b0);
    checkCycle(4'b0010, 2'd1, 1'b0);

    $display("[TB] asynchronous reset mid-grant");
    phase = "t6";
    #3;
    reset = 1'b0;
    #1;
    checkNow(4'b0000, 2'd0, 1'b0);
    #1;
    reset = 1'b1;
    applyStimulus(4'b1100, 1'b0, 8'd0);
    checkCycle(4'b0100, 2'd2, 1'b0);
    applyStimulus(4'b0000, 1'b0, 8'd0);
    checkCycle(4'b0000, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
